// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU datapath engine.
// Operands are shifted in MSB first, one bit per clock. An operation is
// launched with start_i. ADD/SUB/logic/shift ops finish in one cycle.
// When ALU_MUL_EN is defined, op 111 is a WIDTH-cycle shift-add multiplier.
// When it is not defined, op 111 completes in one cycle with result 0 and
// flags {V,C,N,Z} = 0001, and busy_o is never asserted.
//
// state  | meaning
// S_IDLE | accepts loads and start; single-cycle ops complete here
// S_MUL  | shift-add iterations running; loads and start are ignored
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bit_in_i,
    input  logic             load_valid_i,
    input  logic             load_sel_i,
    input  logic [2:0]       op_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH-1:0] alu_res_d;
    logic [3:0]       alu_flags_d;
    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [SW-1:0]    sh_amt;
    logic             alu_c, alu_v;

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;
    state_t               state_q;
    logic [2*WIDTH-1:0]   mcand_q, acc_q, prod_d;
    logic [WIDTH-1:0]     mplier_q;
    logic [SW-1:0]        cnt_q;

    // One shift-add step: accumulate the multiplicand if the current multiplier bit is set.
    always_comb begin
        prod_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end
`endif

    // Single-cycle ALU on the current operand registers. The shifts are done
    // one bit wider than the operand so the last bit shifted out lands in the
    // extra bit (zero when the amount is zero).
    always_comb begin
        sh_amt    = b_q[SW-1:0];
        add_w     = {1'b0, a_q} + {1'b0, b_q};
        sub_w     = {1'b0, a_q} - {1'b0, b_q};
        shl_w     = {1'b0, a_q} << sh_amt;
        shr_w     = {a_q, 1'b0} >> sh_amt;
        alu_res_d = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        case (op_i)
            3'b000: begin
                alu_res_d = add_w[WIDTH-1:0];
                alu_c     = add_w[WIDTH];
                alu_v     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                alu_res_d = sub_w[WIDTH-1:0];
                alu_c     = sub_w[WIDTH];
                alu_v     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: alu_res_d = a_q & b_q;
            3'b011: alu_res_d = a_q | b_q;
            3'b100: alu_res_d = a_q ^ b_q;
            3'b101: begin
                alu_res_d = shl_w[WIDTH-1:0];
                alu_c     = shl_w[WIDTH];
            end
            3'b110: begin
                alu_res_d = shr_w[WIDTH:1];
                alu_c     = shr_w[0];
            end
            default: alu_res_d = '0;
        endcase
        alu_flags_d = {alu_v, alu_c, alu_res_d[WIDTH-1], (alu_res_d == '0)};
    end

    // Operand loading, operation launch, multiplier sequencing and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ALU_MUL_EN
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (load_valid_i && !busy_q) begin
                if (load_sel_i) b_q <= {b_q[WIDTH-2:0], bit_in_i};
                else            a_q <= {a_q[WIDTH-2:0], bit_in_i};
            end
`ifdef ALU_MUL_EN
            if (state_q == S_IDLE) begin
                if (start_i) begin
                    if (op_i == 3'b111) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_q};
                        mplier_q <= b_q;
                        acc_q    <= '0;
                        cnt_q    <= SW'(WIDTH - 1);
                        busy_q   <= 1'b1;
                        state_q  <= S_MUL;
                    end else begin
                        result_q <= alu_res_d;
                        flags_q  <= alu_flags_d;
                        done_q   <= 1'b1;
                    end
                end
            end else begin
                acc_q    <= prod_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                if (cnt_q == '0) begin
                    result_q <= prod_d[WIDTH-1:0];
                    flags_q  <= {1'b0, (prod_d[2*WIDTH-1:WIDTH] != '0),
                                 prod_d[WIDTH-1], (prod_d[WIDTH-1:0] == '0)};
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
`else
            if (start_i) begin
                result_q <= alu_res_d;
                flags_q  <= alu_flags_d;
                done_q   <= 1'b1;
            end
`endif
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign flags_o  = flags_q;
    assign op_a_o   = a_q;
    assign op_b_o   = b_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH = 8). Expected results come from an
// integer-arithmetic reference model; a monitor pops them on every done pulse.
module tb_alu_seq_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bit_in = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_sel = 1'b0;
    logic [2:0]   op = 3'b000;
    logic         start = 1'b0;
    logic         busy, done;
    logic [W-1:0] result, op_a, op_b;
    logic [3:0]   flags;

    int n_tests = 0;
    int n_fail = 0;
    int busy_run = 0;
    int busy_seen = 0;
    int model_a = 0;
    int model_b = 0;
    logic [11:0] exp_q[$];

    alu_seq_core #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .bit_in_i(bit_in), .load_valid_i(load_valid),
        .load_sel_i(load_sel), .op_i(op), .start_i(start), .busy_o(busy),
        .done_o(done), .result_o(result), .flags_o(flags), .op_a_o(op_a), .op_b_o(op_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic int sx(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Reference model: returns {V,C,N,Z, result[7:0]}.
    function automatic logic [11:0] ref_model(input int o, input int a, input int b);
        int r, c, v, n, s, ss;
        logic [7:0] r8;
        c = 0; v = 0; r = 0;
        n = b % 8;
        case (o)
            0: begin s = a + b; r = s % 256; c = (s > 255); ss = sx(a) + sx(b); v = (ss > 127 || ss < -128); end
            1: begin s = a - b + 256; r = s % 256; c = (a < b); ss = sx(a) - sx(b); v = (ss > 127 || ss < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * (1 << n)) % 256; c = (n == 0) ? 0 : (a / (1 << (8 - n))) % 2; end
            6: begin r = a / (1 << n); c = (n == 0) ? 0 : (a / (1 << (n - 1))) % 2; end
            default: begin
`ifdef ALU_MUL_EN
                s = a * b; r = s % 256; c = (s > 255);
`else
                r = 0;
`endif
            end
        endcase
        r8 = r[7:0];
        return {v[0], c[0], r8[7], (r == 0), r8};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy && cnt < 100) begin tick(); cnt++; end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin tick(); cnt++; end
        if (exp_q.size() != 0) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic load_bits(input int sel, input int value, input int nbits);
        wait_idle();
        for (int i = nbits - 1; i >= 0; i--) begin
            int bv;
            bv = (value / (1 << i)) % 2;
            bit_in = bv[0];
            load_sel = sel[0];
            load_valid = 1'b1;
            tick();
            if (sel != 0) model_b = (model_b * 2 + bv) % 256;
            else          model_a = (model_a * 2 + bv) % 256;
        end
        load_valid = 1'b0;
    endtask

    task automatic load_ab(input int a, input int b);
        load_bits(0, a, 8);
        load_bits(1, b, 8);
        check("op_a_load", op_a, model_a);
        check("op_b_load", op_b, model_b);
    endtask

    task automatic issue(input int o);
        wait_idle();
        op = o[2:0];
        start = 1'b1;
        exp_q.push_back(ref_model(o, model_a, model_b));
        tick();
        start = 1'b0;
    endtask

    // Monitor: compare every done pulse against the scoreboard, track busy length.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy) begin
                    busy_run++;
                    busy_seen++;
                end else if (busy_run != 0) begin
                    check("busy_len", busy_run, W);
                    busy_run = 0;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        logic [11:0] e;
                        e = exp_q.pop_front();
                        check("result", result, e[7:0]);
                        check("flags", flags, e[11:8]);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        rst = 1'b0;
        tick();

        load_ab(8'h7F, 8'h01);
        issue(0);
        check("add_done_next", done, 1);
        wait_drain();
        check("add_7f_res", result, 8'h80);
        check("add_7f_flags", flags, 4'b1010);

        load_ab(8'h00, 8'h01);
        issue(1);
        wait_drain();
        check("sub_res", result, 8'hFF);
        check("sub_flags", flags, 4'b0110);

        load_ab(8'h81, 8'h01);
        issue(5);
        wait_drain();
        check("shl_res", result, 8'h02);
        check("shl_flags", flags, 4'b0100);

        load_ab(8'h01, 8'h01);
        wait_idle();
        op = 3'b000; start = 1'b1;
        load_valid = 1'b1; load_sel = 1'b0; bit_in = 1'b1;
        exp_q.push_back(ref_model(0, model_a, model_b));
        tick();
        start = 1'b0; load_valid = 1'b0;
        model_a = 3;
        wait_drain();
        check("same_cycle_res", result, 8'h02);
        check("same_cycle_op_a", op_a, 8'h03);

`ifdef ALU_MUL_EN
        load_ab(8'h0F, 8'h11);
        issue(7);
        check("mul_busy", busy, 1);
        tick();
        load_valid = 1'b1; load_sel = 1'b0; bit_in = 1'b1;
        start = 1'b1; op = 3'b000;
        tick();
        load_valid = 1'b1; load_sel = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        check("mul_op_a_held", op_a, 8'h0F);
        check("mul_op_b_held", op_b, 8'h11);
        wait_drain();
        repeat (3) tick();
        check("mul_res", result, 8'hFF);
        check("mul_flags", flags, 4'b0010);

        load_ab(8'h10, 8'h10);
        issue(7);
        wait_drain();
        check("mul_ovf_res", result, 8'h00);
        check("mul_ovf_flags", flags, 4'b0101);

        load_ab(8'h33, 8'h07);
        issue(7);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_flags", flags, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_op_a", op_a, 0);
        exp_q.delete();
        busy_run = 0;
        model_a = 0; model_b = 0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_done", done, 0);
`else
        load_ab(8'h05, 8'h03);
        issue(7);
        check("nomul_done_next", done, 1);
        check("nomul_busy", busy, 0);
        wait_drain();
        check("nomul_res", result, 0);
        check("nomul_flags", flags, 4'b0001);
`endif

        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 3);
            if (k == 0)      load_bits(0, $urandom_range(0, 255), 8);
            else if (k == 1) load_bits(1, $urandom_range(0, 255), 8);
            else if (k == 2) load_bits($urandom_range(0, 1), $urandom_range(0, 7), 3);
            issue($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) issue($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) wait_drain();
        end
        wait_drain();
        repeat (3) tick();
        check("final_ops", op_a * 256 + op_b, model_a * 256 + model_b);
`ifndef ALU_MUL_EN
        check("busy_never", busy_seen, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised sequential ALU core: operands are loaded serially, one bit per clock, into internal A/B registers, then an operation is launched with a `start` strobe. Single-cycle ops complete on the next cycle. An optional multi-cycle shift-add multiplier runs for WIDTH cycles. Results and flags are registered and held, and a `busy`/`done` handshake is provided. It is the datapath engine behind the top-level pin wrapper, which maps board inputs onto `bit_in`/`load_*`/`op`/`start` and muxes `result`/`flags` onto the outputs.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥ 4. Shift amount width SW = $clog2(WIDTH).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- bit_in  in  1  serial operand bit
- load_valid  in  1  shift `bit_in` into the selected operand this cycle
- load_sel  in  1  0 = A, 1 = B
- op  in  3  operation code, sampled on accepted `start`
- start  in  1  launch operation; ignored while `busy`
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: `result`/`flags` just updated
- result  out  WIDTH  registered result, held until next completion
- flags  out  4  registered {V, C, N, Z}
- op_a  out  WIDTH  current A register (readback)
- op_b  out  WIDTH  current B register (readback)

## Operation
- Loading: when `load_valid` is high and not `busy`, the selected register becomes {reg[WIDTH-2:0], bit_in}, i.e. MSB first. `load_valid` is ignored while `busy`.
- Op codes:
  - 000 ADD A+B
  - 001 SUB A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL A by B[SW-1:0]
  - 110 SHR (logical) A by B[SW-1:0]
  - 111 MUL, low WIDTH bits of A×B unsigned
- Flags:
  - Z = (result == 0); N = result[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (A < B unsigned); V = signed overflow.
  - Logic ops: C = V = 0.
  - Shifts: C = last bit shifted out (0 if amount is 0); V = 0.
  - MUL: C = 1 if the high WIDTH bits of the product are nonzero; V = 0.
- States:
  - IDLE: `start` with op ≠ 111 → compute, register result/flags, pulse `done`, stay IDLE. `start` with op = 111 → MUL.
  - MUL: WIDTH iterations of shift-add on internal copies of A/B/accumulator (2·WIDTH bits); after the last iteration, register result/flags, pulse `done` → IDLE.
- Operands are copied at `start` acceptance. A `load_valid` in the same cycle as an accepted `start` still updates the register, but the operation uses the pre-load values.
- `start` while `busy`: ignored, no queueing.
- Reset (any time, including mid-MUL): state = IDLE; A, B, result = 0; flags = 0000; busy = 0; done = 0; MUL partial results discarded.

## Timing
- Single-cycle op: `start` sampled at edge k → result/flags valid and `done` = 1 during the cycle after edge k; `done` = 0 after edge k+1.
- MUL: accepted at edge k → `busy` = 1 from edge k through edge k+WIDTH−1; at edge k+WIDTH, result/flags update, `done` = 1, `busy` = 0. Total latency is WIDTH cycles.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high.
- `op_a`/`op_b` reflect loads one cycle after the `load_valid` edge.

## Configuration
- ALU_MUL_EN defined: op 111 is the multi-cycle multiplier as above.
- ALU_MUL_EN undefined: no MUL state or multiplier logic. Op 111 completes single-cycle with result = 0, flags = {V=0, C=0, N=0, Z=1}; `busy` is never asserted.

## Test plan
- Reset, load A = 0x7F, B = 0x01 (8 bits each, MSB first), start ADD → `done` next cycle, result 0x80, flags V=1 C=0 N=1 Z=0.
- A = 0x00, B = 0x01, SUB → result 0xFF, C=1 N=1 V=0 Z=0; then A = 0x81, B = 0x01, SHL → 0x02, C=1.
- MUL (ALU_MUL_EN): 0x0F×0x11 → 0xFF, C=0, `busy` high exactly 8 cycles. 0x10×0x10 → 0x00, Z=1 C=1.
- During MUL: pulse `load_valid` and `start` → A/B unchanged, no extra `done`. Assert `rst` at cycle 4 of MUL → busy = 0, result = 0x00, flags = 0000 immediately.
- Same-cycle `start` ADD + `load_valid` on A (A = 0x01, B = 0x01, bit_in = 1) → result 0x02, then `op_a` = 0x03.
- Without ALU_MUL_EN: op 111 with A = 0x05, B = 0x03 → `done` next cycle, result 0x00, flags Z=1, `busy` never high.
